// File: rtl/core_pip_ma_lsu_if.sv
// Data-memory bus between the MA stage (master) and the data memory (slave):
// request/grant handshake followed by a separate load-response phase.
interface core_pip_ma_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/core_pip_ma_lsu.sv
// KayRV32 memory-access stage: issues loads/stores with byte-lane steering,
// stalls EX while an access is outstanding, traps misalignment and bus timeouts.
module core_pip_ma_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [4:0]        decoded_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  input  logic [31:0]       alu_data,
  output logic              stall,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_we,
  output logic              exc,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr,
  core_pip_ma_lsu_if.master mem
);

  localparam logic [4:0] OP_LB  = 5'd1;
  localparam logic [4:0] OP_LH  = 5'd2;
  localparam logic [4:0] OP_LW  = 5'd3;
  localparam logic [4:0] OP_LBU = 5'd4;
  localparam logic [4:0] OP_LHU = 5'd5;
  localparam logic [4:0] OP_SB  = 5'd6;
  localparam logic [4:0] OP_SH  = 5'd7;
  localparam logic [4:0] OP_SW  = 5'd8;

  localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [4:0]        op_reg;
  logic [4:0]        rd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              load_reg;

  logic              wb_we_reg, exc_reg;
  logic [4:0]        wb_rd_reg;
  logic [31:0]       wb_data_reg;
  logic [1:0]        exc_cause_reg;
  logic [ADDR_W-1:0] exc_addr_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_be_reg;

  logic        is_load, is_store, is_byte, is_half, is_word, misaligned, accept;
  logic        timed_out, store_done, resp_done, abort;
  logic [31:0] st_wdata, load_data;
  logic [3:0]  st_be;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [7:0]  rbyte [4];

  always_comb begin
    is_load    = (decoded_op == OP_LB) || (decoded_op == OP_LH) || (decoded_op == OP_LW) ||
                 (decoded_op == OP_LBU) || (decoded_op == OP_LHU);
    is_store   = (decoded_op == OP_SB) || (decoded_op == OP_SH) || (decoded_op == OP_SW);
    is_byte    = (decoded_op == OP_LB) || (decoded_op == OP_LBU) || (decoded_op == OP_SB);
    is_half    = (decoded_op == OP_LH) || (decoded_op == OP_LHU) || (decoded_op == OP_SH);
    is_word    = (decoded_op == OP_LW) || (decoded_op == OP_SW);
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    accept     = (state_reg == IDLE) && valid && (is_load || is_store) && !misaligned;
  end

  // Byte enables mark the addressed lanes for loads as well as stores.
  always_comb begin
    st_wdata = '0;
    st_be    = 4'b1111;
    if (is_byte)
      st_be = 4'b0001 << addr[1:0];
    else if (is_half)
      st_be = addr[1] ? 4'b1100 : 4'b0011;
    if (decoded_op == OP_SB)
      st_wdata = {4{store_data[7:0]}};
    else if (decoded_op == OP_SH)
      st_wdata = {2{store_data[15:0]}};
    else if (decoded_op == OP_SW)
      st_wdata = store_data;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
    assign rbyte[gi] = mem.rdata[8*gi +: 8];
  end

  always_comb begin
    load_byte = rbyte[addr_reg[1:0]];
    load_half = addr_reg[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    case (op_reg)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'h0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'h0, load_half};
      default: load_data = mem.rdata;
    endcase
  end

  // A load grant on the final budget cycle still moves to RESP; the abort then fires there.
  always_comb begin
    timed_out  = (TIMEOUT != 0) && (int'(cnt_reg) >= TIMEOUT - 1);
    store_done = (state_reg == REQ) && mem.gnt && !load_reg;
    resp_done  = (state_reg == RESP) && mem.rvalid;
    abort      = timed_out && (((state_reg == REQ) && !mem.gnt) ||
                               ((state_reg == RESP) && !mem.rvalid));
    stall      = accept ||
                 ((state_reg == REQ) && !store_done && !abort) ||
                 ((state_reg == RESP) && !resp_done && !abort);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      rd_reg        <= '0;
      addr_reg      <= '0;
      load_reg      <= 1'b0;
      wb_we_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
      exc_reg       <= 1'b0;
      exc_cause_reg <= '0;
      exc_addr_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
    end else begin
      wb_we_reg <= 1'b0;
      exc_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid && (is_load || is_store)) begin
            if (misaligned) begin
              exc_reg       <= 1'b1;
              exc_cause_reg <= is_load ? 2'b01 : 2'b10;
              exc_addr_reg  <= addr;
            end else begin
              op_reg        <= decoded_op;
              rd_reg        <= rd;
              addr_reg      <= addr;
              load_reg      <= is_load;
              cnt_reg       <= '0;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= is_store;
              mem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata_reg <= st_wdata;
              mem_be_reg    <= st_be;
              state_reg     <= REQ;
            end
          end else if (valid) begin
            wb_rd_reg   <= rd;
            wb_data_reg <= alu_data;
            wb_we_reg   <= (rd != 5'd0);
          end
        end
        REQ, RESP: begin
          if (int'(cnt_reg) < TIMEOUT)
            cnt_reg <= cnt_reg + CNT_W'(1);
          if (state_reg == REQ && mem.gnt) begin
            mem_req_reg <= 1'b0;
            state_reg   <= load_reg ? RESP : IDLE;
          end else if (resp_done) begin
            wb_rd_reg   <= rd_reg;
            wb_data_reg <= load_data;
            wb_we_reg   <= (rd_reg != 5'd0);
            state_reg   <= IDLE;
          end else if (abort) begin
            mem_req_reg   <= 1'b0;
            exc_reg       <= 1'b1;
            exc_cause_reg <= 2'b11;
            exc_addr_reg  <= addr_reg;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wb_we     = wb_we_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_data   = wb_data_reg;
  assign exc       = exc_reg;
  assign exc_cause = exc_cause_reg;
  assign exc_addr  = exc_addr_reg;
  assign mem.req   = mem_req_reg;
  assign mem.we    = mem_we_reg;
  assign mem.addr  = mem_addr_reg;
  assign mem.wdata = mem_wdata_reg;
  assign mem.be    = mem_be_reg;

endmodule

// File: tb/tb_core_pip_ma_lsu.sv
// Scoreboard bench for core_pip_ma_lsu: stimulus queues expected bus requests and
// write-back/exception events; a negedge monitor pops and compares them.
module tb_core_pip_ma_lsu;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_LB  = 5'd1;
  localparam logic [4:0] OP_LH  = 5'd2;
  localparam logic [4:0] OP_LW  = 5'd3;
  localparam logic [4:0] OP_LBU = 5'd4;
  localparam logic [4:0] OP_LHU = 5'd5;
  localparam logic [4:0] OP_SB  = 5'd6;
  localparam logic [4:0] OP_SH  = 5'd7;
  localparam logic [4:0] OP_SW  = 5'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic [4:0]  rd = '0;
  logic [31:0] alu_data = '0;
  logic        stall, wb_we, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  core_pip_ma_lsu_if #(.ADDR_W(32)) bus ();

  core_pip_ma_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .decoded_op(op), .addr(addr),
    .store_data(sdata), .rd(rd), .alu_data(alu_data), .stall(stall),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we), .exc(exc),
    .exc_cause(exc_cause), .exc_addr(exc_addr), .mem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic        is_exc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] eaddr;
  } rsp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] rdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_load;
  } vec_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur_req;
  bit   req_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: request fields are checked every cycle the request is held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.req) begin
        if (!req_active) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected: got addr 0x%0h expected no request", bus.addr);
            cur_req = '{addr: 32'hx, we: 1'bx, wdata: 32'hx, be: 4'hx};
          end else begin
            cur_req = req_q.pop_front();
            $display("req  addr=0x%08h we=%0b wdata=0x%08h be=%04b", bus.addr, bus.we, bus.wdata, bus.be);
          end
          req_active = 1'b1;
        end
        check("req_addr", 64'(bus.addr), 64'(cur_req.addr));
        check("req_we", 64'(bus.we), 64'(cur_req.we));
        check("req_wdata", 64'(bus.wdata), 64'(cur_req.wdata));
        check("req_be", 64'(bus.be), 64'(cur_req.be));
      end else begin
        req_active = 1'b0;
      end
      if (wb_we || exc) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got we=%0b exc=%0b rd=%0d data=0x%0h expected no event",
                   wb_we, exc, wb_rd, wb_data);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_is_exc", 64'(exc), 64'(e.is_exc));
          if (e.is_exc) begin
            check("exc_cause", 64'(exc_cause), 64'(e.cause));
            check("exc_addr", 64'(exc_addr), 64'(e.eaddr));
            check("exc_no_wb", 64'(wb_we), 64'd0);
            $display("exc  cause=%02b addr=0x%08h", exc_cause, exc_addr);
          end else begin
            check("wb_rd", 64'(wb_rd), 64'(e.rd));
            check("wb_data", 64'(wb_data), 64'(e.data));
            $display("wb   rd=%0d data=0x%08h", wb_rd, wb_data);
          end
        end
      end
    end
  end

  // Runs one aligned access; called at posedge+1, returns at posedge+1.
  task automatic run_mem(input vec_t v);
    bit is_ld;
    is_ld = (v.op == OP_LB) || (v.op == OP_LH) || (v.op == OP_LW) ||
            (v.op == OP_LBU) || (v.op == OP_LHU);
    req_q.push_back('{addr: v.exp_maddr, we: !is_ld, wdata: v.exp_wdata, be: v.exp_be});
    if (is_ld && v.rd != 5'd0)
      rsp_q.push_back('{is_exc: 1'b0, rd: v.rd, data: v.exp_load, cause: 2'b00, eaddr: 32'h0});
    valid = 1'b1; op = v.op; addr = v.addr; sdata = v.sdata; rd = v.rd; alu_data = 32'h5555_5555;
    @(negedge clk); check("stall_accept", 64'(stall), 64'd1);
    step();
    for (int i = 0; i < v.gnt_wait; i++) begin
      @(negedge clk); check("stall_gnt_wait", 64'(stall), 64'd1);
      step();
    end
    bus.gnt = 1'b1;
    @(negedge clk); check("stall_gnt", 64'(stall), 64'(is_ld));
    step();
    bus.gnt = 1'b0;
    if (!is_ld) begin
      valid = 1'b0;
      return;
    end
    for (int i = 0; i < v.rv_wait; i++) begin
      @(negedge clk); check("stall_rv_wait", 64'(stall), 64'd1);
      step();
    end
    bus.rvalid = 1'b1; bus.rdata = v.rdata;
    @(negedge clk); check("stall_rvalid", 64'(stall), 64'd0);
    step();
    bus.rvalid = 1'b0; valid = 1'b0;
    @(negedge clk); check("wb_we_latency", 64'(wb_we), 64'(v.rd != 5'd0));
    step();
  endtask

  task automatic run_misaligned(input logic [4:0] o, input logic [31:0] a, input logic [1:0] cause);
    rsp_q.push_back('{is_exc: 1'b1, rd: 5'd0, data: 32'h0, cause: cause, eaddr: a});
    valid = 1'b1; op = o; addr = a; rd = 5'd9; sdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("mis_stall", 64'(stall), 64'd0);
    check("mis_no_req", 64'(bus.req), 64'd0);
    step();
    valid = 1'b0;
    @(negedge clk);
    check("mis_exc", 64'(exc), 64'd1);
    check("mis_no_req_next", 64'(bus.req), 64'd0);
    step();
  endtask

  task automatic run_alu(input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0)
      rsp_q.push_back('{is_exc: 1'b0, rd: r, data: d, cause: 2'b00, eaddr: 32'h0});
    valid = 1'b1; op = OP_ADD; rd = r; alu_data = d; addr = 32'h0;
    @(negedge clk); check("alu_stall", 64'(stall), 64'd0);
    step();
    valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    //        op      addr          sdata          rd  gw rw rdata          maddr          wdata          be       load
    vecs[0] = '{OP_LB,  32'h0000_1003, 32'h0,         5'd10, 0, 0, 32'h80FF_0000, 32'h0000_1000, 32'h0,         4'b1000, 32'hFFFF_FF80};
    vecs[1] = '{OP_LBU, 32'h0000_1003, 32'h0,         5'd11, 0, 0, 32'h80FF_0000, 32'h0000_1000, 32'h0,         4'b1000, 32'h0000_0080};
    vecs[2] = '{OP_SH,  32'h0000_2002, 32'h1234_ABCD, 5'd0,  3, 0, 32'h0,         32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0};
    vecs[3] = '{OP_SB,  32'h0000_7001, 32'h0000_00A5, 5'd0,  0, 0, 32'h0,         32'h0000_7000, 32'hA5A5_A5A5, 4'b0010, 32'h0};
    vecs[4] = '{OP_LHU, 32'h0000_7000, 32'h0,         5'd12, 1, 0, 32'h1234_F00D, 32'h0000_7000, 32'h0,         4'b0011, 32'h0000_F00D};
    vecs[5] = '{OP_SW,  32'h0000_7004, 32'hCAFE_F00D, 5'd0,  0, 0, 32'h0,         32'h0000_7004, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[6] = '{OP_LW,  32'h0000_7008, 32'h0,         5'd31, 0, 1, 32'h1234_5678, 32'h0000_7008, 32'h0,         4'b1111, 32'h1234_5678};
    vecs[7] = '{OP_LW,  32'h0000_5000, 32'h0,         5'd0,  0, 0, 32'hDEAD_BEEF, 32'h0000_5000, 32'h0,         4'b1111, 32'h0};
    vecs[8] = '{OP_LH,  32'h0000_6002, 32'h0,         5'd6,  0, 0, 32'h8001_7FFF, 32'h0000_6000, 32'h0,         4'b1100, 32'hFFFF_8001};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb", {wb_we, wb_rd, wb_data}, 64'd0);
    check("rst_exc", {exc, exc_cause, exc_addr}, 64'd0);
    check("rst_req", {bus.req, bus.we, bus.be, bus.addr}, 64'd0);
    check("rst_wdata", 64'(bus.wdata), 64'd0);
    mon_en = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_mem(vecs[i]);

    run_misaligned(OP_LW, 32'h0000_3001, 2'b01);
    run_misaligned(OP_SH, 32'h0000_3001, 2'b10);

    // Bus timeout: grant never arrives, then a stray response in IDLE.
    req_q.push_back('{addr: 32'h0000_4000, we: 1'b0, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{is_exc: 1'b1, rd: 5'd0, data: 32'h0, cause: 2'b11, eaddr: 32'h0000_4000});
    valid = 1'b1; op = OP_LW; addr = 32'h0000_4000; rd = 5'd3;
    @(negedge clk); check("to_stall_accept", 64'(stall), 64'd1);
    step();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); check("to_stall_req", 64'(stall), 64'd1);
      step();
    end
    @(negedge clk);
    check("to_stall_abort", 64'(stall), 64'd0);
    check("to_req_last", 64'(bus.req), 64'd1);
    step();
    valid = 1'b0;
    @(negedge clk);
    check("to_req_dropped", 64'(bus.req), 64'd0);
    check("to_exc", 64'(exc), 64'd1);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    step();
    bus.rvalid = 1'b0;
    @(negedge clk); check("to_late_rvalid", 64'(wb_we), 64'd0);
    step();

    run_alu(5'd5, 32'd7);
    run_mem(vecs[7]);

    // Reset while waiting for a load response.
    req_q.push_back('{addr: 32'h0000_6000, we: 1'b0, wdata: 32'h0, be: 4'b1111});
    valid = 1'b1; op = OP_LW; addr = 32'h0000_6000; rd = 5'd4;
    step();
    bus.gnt = 1'b1;
    step();
    bus.gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("mrst_stall", 64'(stall), 64'd0);
    check("mrst_wb", {wb_we, wb_rd, wb_data}, 64'd0);
    check("mrst_exc", {exc, exc_cause, exc_addr}, 64'd0);
    check("mrst_req", {bus.req, bus.we, bus.be, bus.addr}, 64'd0);
    check("mrst_wdata", 64'(bus.wdata), 64'd0);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
    step();
    bus.rvalid = 1'b0;
    @(negedge clk); check("mrst_stale_rvalid", 64'(wb_we), 64'd0);
    step();
    run_mem(vecs[8]);

    repeat (3) step();
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
